// File: rtl/remote_comm_pkg.sv
// Shared constants and state encodings for the remote command link.
package remote_comm_pkg;

  // 50 MHz system clock / 19200 baud
  localparam int unsigned BaudDivDefault = 2604;
  // 8N1: start + 8 data + stop
  localparam int unsigned BitsPerFrame   = 10;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } cmd_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/remote_comm_uart.sv
// Full-duplex 8N1 UART: independent transmit and receive halves.
module uart
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);

  localparam int unsigned CntW = $clog2(BAUD_DIV + 1);
  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] BaudHalf = CntW'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]      TxBitLast = 4'(BitsPerFrame - 1);

  logic            tx_busy_q, tx_busy_d;
  logic [CntW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [8:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CntW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rdy_q, rdy_d;

  assign TX      = tx_q;
  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;

  // Transmit next-state: load frame on trmt, shift one bit per baud period.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_done    = 1'b0;
    if (!tx_busy_q) begin
      if (trmt) begin
        tx_busy_d  = 1'b1;
        tx_baud_d  = '0;
        tx_bit_d   = '0;
        tx_shift_d = {1'b1, tx_data};
        tx_d       = 1'b0;
      end
    end else if (tx_baud_q == BaudLast) begin
      tx_baud_d = '0;
      if (tx_bit_q == TxBitLast) begin
        // stop bit already on the line; it simply stays high
        tx_busy_d = 1'b0;
        tx_done   = 1'b1;
      end else begin
        tx_d       = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[8:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
      end
    end else begin
      tx_baud_d = tx_baud_q + 1'b1;
    end
  end

  // Receive next-state: falling edge starts a frame, sample at bit centres.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rdy_d      = rdy_q;
    if (clr_rdy) rdy_d = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RxStart;
          rx_baud_d  = '0;
          rdy_d      = 1'b0;
        end
      end
      RxStart: begin
        if (rx_baud_q == BaudHalf) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          // high at mid start bit means it was a glitch
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_baud_q == BaudLast) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_baud_q == BaudLast) begin
          rx_baud_d  = '0;
          rx_data_d  = rx_shift_q;
          rdy_d      = 1'b1;
          rx_state_d = RxIdle;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Transmit state registers; line idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy_q  <= 1'b0;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // Receive state registers; synchronizer resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rdy_q      <= 1'b0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
    end
  end

endmodule

// File: rtl/remote_comm.sv
// Sends a 16-bit command as two back-to-back UART bytes (high first) and
// exposes the last response byte received from the maze runner.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  cmd_state_e  state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic        start_q, start_d;
  logic        cmd_sent_q, cmd_sent_d;
  logic        tx_done;
  logic        send_accept;
  logic [7:0]  tx_byte;

  assign send_accept = (state_q == StIdle) && send_cmd;
  assign tx_byte     = (state_q == StLow) ? cmd_q[7:0] : cmd_q[15:8];
  assign cmd_sent    = cmd_sent_q;

  // Byte sequencing: latch on accept, then high byte, then low byte.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    start_d    = 1'b0;
    cmd_sent_d = cmd_sent_q;
    unique case (state_q)
      StIdle: begin
        if (send_cmd) begin
          cmd_d      = cmd;
          cmd_sent_d = 1'b0;
          start_d    = 1'b1;
          state_d    = StHigh;
        end
      end
      StHigh: begin
        if (tx_done) begin
          start_d = 1'b1;
          state_d = StLow;
        end
      end
      StLow: begin
        if (tx_done) begin
          cmd_sent_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      start_q    <= 1'b0;
      cmd_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      start_q    <= start_d;
      cmd_sent_q <= cmd_sent_d;
    end
  end

  uart #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk    (clk),
    .rst    (rst),
    .trmt   (start_q),
    .tx_data(tx_byte),
    .tx_done(tx_done),
    .TX     (TX),
    .RX     (RX),
    .clr_rdy(send_accept),
    .rx_data(resp),
    .rdy    (resp_rdy)
  );

endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: stimulus pushes expectations, monitors
// decode TX frames, cmd_sent rises and resp_rdy rises and compare.
module tb_remote_comm;

  localparam int B = 16;

  logic        clk;
  logic        rst;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        RX;
  logic        cmd_sent;
  logic        TX;
  logic [7:0]  resp;
  logic        resp_rdy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] tx_exp[$];
  int         sent_exp[$];
  logic [7:0] resp_exp[$];
  int         rx_start[$];

  remote_comm #(
    .BAUD_DIV(B)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cmd),
    .send_cmd(send_cmd),
    .cmd_sent(cmd_sent),
    .TX      (TX),
    .RX      (RX),
    .resp    (resp),
    .resp_rdy(resp_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic wait_neg(input int n, output bit hit);
    hit = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (rst) hit = 1'b1;
    end
  endtask

  // TX frame monitor: decode 8N1 at bit centres, abort on reset.
  initial begin : tx_mon
    logic [7:0] b;
    bit         ab;
    forever begin
      @(negedge clk);
      if (!rst && TX === 1'b0) begin
        wait_neg(B / 2, ab);
        if (!ab) check("tx_start_bit", int'(TX), 0);
        for (int i = 0; i < 8 && !ab; i++) begin
          wait_neg(B, ab);
          b[i] = TX;
        end
        if (!ab) wait_neg(B, ab);
        if (!ab) begin
          check("tx_stop_bit", int'(TX), 1);
          if (tx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got frame 0x%0h expected none", b);
          end else begin
            check("tx_byte", int'(b), int'(tx_exp.pop_front()));
          end
        end else begin
          wait (rst == 1'b0);
        end
      end
    end
  end

  // cmd_sent rise monitor: one expected rise per accepted command.
  initial begin : sent_mon
    logic prev;
    int   iss;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_sent && !prev) begin
        if (sent_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_sent_unexpected: got rise at cycle %0d expected none", cyc);
        end else begin
          iss = sent_exp.pop_front();
          check_range("cmd_sent_latency", cyc - iss, 20 * B + 1, 20 * B + 3);
        end
      end
      prev = cmd_sent;
    end
  end

  // resp_rdy rise monitor: compare byte and latency from start edge.
  initial begin : resp_mon
    logic prev;
    int   st;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_rdy && !prev) begin
        if (resp_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got 0x%0h expected none", resp);
        end else begin
          check("resp_byte", int'(resp), int'(resp_exp.pop_front()));
          st = rx_start.pop_front();
          check_range("resp_latency", cyc - st, (19 * B) / 2 + 1, (19 * B) / 2 + 5);
        end
      end
      prev = resp_rdy;
    end
  end

  task automatic send(input logic [15:0] c, input bit accept);
    @(negedge clk);
    cmd      = c;
    send_cmd = 1'b1;
    if (accept) begin
      tx_exp.push_back(c[15:8]);
      tx_exp.push_back(c[7:0]);
      sent_exp.push_back(cyc + 1);
    end
    @(negedge clk);
    send_cmd = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    resp_exp.push_back(b);
    rx_start.push_back(cyc);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  task automatic wait_cmd_sent(input string nm);
    int n;
    n = 0;
    while (!cmd_sent && n < 20 * B + 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(cmd_sent), 1);
  endtask

  initial begin
    rst      = 1'b0;
    cmd      = 16'h0000;
    send_cmd = 1'b0;
    RX       = 1'b1;
    #1 rst = 1'b1;

    // reset values, held while rst stays high
    for (int k = 0; k < 2; k++) begin
      repeat (3) @(negedge clk);
      check("rst_tx", int'(TX), 1);
      check("rst_cmd_sent", int'(cmd_sent), 0);
      check("rst_resp_rdy", int'(resp_rdy), 0);
      check("rst_resp", int'(resp), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 0x4002, cmd changed right after latching must not matter
    send(16'h4002, 1'b1);
    cmd = 16'hFFFF;
    check("sent_low_after_accept", int'(cmd_sent), 0);
    wait_cmd_sent("cmd_sent_4002");

    // 0xA5 response
    rx_byte(8'hA5);
    repeat (4) @(negedge clk);
    check("resp_rdy_a5", int'(resp_rdy), 1);

    // short glitch on RX: no new byte, resp unchanged
    @(negedge clk);
    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (2 * B) @(negedge clk);
    check("glitch_resp_held", int'(resp), 8'hA5);

    // second send during the high byte is ignored
    send(16'h2000, 1'b1);
    repeat (3 * B) @(negedge clk);
    send(16'h23FF, 1'b0);
    wait_cmd_sent("cmd_sent_2000");
    repeat (2 * B) @(negedge clk);

    // reset in the middle of the low byte
    send(16'h55AA, 1'b1);
    repeat (13 * B) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx", int'(TX), 1);
    check("midrst_cmd_sent", int'(cmd_sent), 0);
    tx_exp.delete();
    sent_exp.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * B) @(negedge clk);
    check("postrst_tx_idle", int'(TX), 1);
    check("postrst_cmd_sent", int'(cmd_sent), 0);
    send(16'h6001, 1'b1);
    wait_cmd_sent("cmd_sent_6001");

    // two commands, each answered with 0xA5; second overlaps RX and TX
    send(16'h7E81, 1'b1);
    check("c1_cmd_sent_fall", int'(cmd_sent), 0);
    wait_cmd_sent("cmd_sent_7e81");
    rx_byte(8'hA5);
    repeat (4) @(negedge clk);
    check("c1_resp_rdy", int'(resp_rdy), 1);
    send(16'h0F3C, 1'b1);
    check("c2_cmd_sent_fall", int'(cmd_sent), 0);
    check("c2_resp_rdy_fall", int'(resp_rdy), 0);
    fork
      rx_byte(8'hA5);
      wait_cmd_sent("cmd_sent_0f3c");
    join
    repeat (4) @(negedge clk);
    check("c2_resp_rdy", int'(resp_rdy), 1);
    check("c2_resp", int'(resp), 8'hA5);

    // drain and confirm every expectation was consumed
    repeat (3 * B) @(negedge clk);
    check("tx_exp_left", tx_exp.size(), 0);
    check("sent_exp_left", sent_exp.size(), 0);
    check("resp_exp_left", resp_exp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/remote_comm.md
REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 Parameter: BAUD_DIV, default 2604, clocks per UART bit (50 MHz / 19200 baud).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-high.
REQ-004 Port: cmd  input  16  command word to transmit.
REQ-005 Port: send_cmd  input  1  one-cycle pulse; requests transmission of cmd.
REQ-006 Port: cmd_sent  output  1  level; high once both command bytes are fully transmitted.
REQ-007 Port: TX  output  1  UART serial out to the maze runner; idles high.
REQ-008 Port: RX  input  1  UART serial in from the maze runner; asynchronous to clk.
REQ-009 Port: resp  output  8  last response byte received (0xA5 = positive acknowledge).
REQ-010 Port: resp_rdy  output  1  level; high when resp holds a newly received byte.

Function
REQ-011 UART frame SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each exactly BAUD_DIV clocks.
REQ-012 Command FSM states SHALL be IDLE, HIGH (sending cmd[15:8]), LOW (sending cmd[7:0]).
REQ-013 In IDLE, send_cmd SHALL latch cmd, clear cmd_sent, and start the high-byte frame on the next cycle (-> HIGH).
REQ-014 On high-byte frame completion, the low byte SHALL start the next cycle with no idle gap (-> LOW).
REQ-015 On low-byte frame completion, cmd_sent SHALL be set and the FSM SHALL return to IDLE; cmd_sent holds until the next accepted send_cmd or reset.
REQ-016 send_cmd in HIGH or LOW SHALL be ignored; the latched word and frames are unaffected.
REQ-017 Changes on cmd after latching SHALL NOT affect the transmitted bytes.
REQ-018 RX SHALL be double-flop synchronized before use; receiver idles waiting for a falling edge (start bit).
REQ-019 Receiver SHALL sample start bit at BAUD_DIV/2; if it reads 1 (glitch), return to idle without effect.
REQ-020 Data bits SHALL be sampled at the centre of each bit period, shifted LSB first.
REQ-021 At the stop-bit centre sample, resp SHALL load the received byte and resp_rdy SHALL be set, regardless of stop-bit value (no framing error flag).
REQ-022 resp_rdy SHALL clear on an accepted send_cmd or on detection of the next start bit; resp holds its value until the next byte completes.
REQ-023 Transmitter and receiver SHALL operate independently and simultaneously (full duplex).
REQ-024 Total command latency send_cmd -> cmd_sent SHALL be 20*BAUD_DIV + 2 clocks, +/-1.

Reset
REQ-025 Asserting rst SHALL immediately force: FSM IDLE, TX=1, cmd_sent=0, resp_rdy=0, resp=0x00, all counters and shift registers 0.
REQ-026 Reset mid-frame SHALL abort TX and RX frames; after release no partial frame resumes.

Structure
REQ-027 Shared package SHALL hold BAUD_DIV default, bit-count constant (10 bits/frame) and the FSM state enum.
REQ-028 One sub-module, uart (tx + rx halves: trmt/tx_data/tx_done, rx_data/rdy), SHALL be instantiated; remote_comm contains only the byte-sequencing FSM and latches.

Verification
REQ-029 Reset asserted -> TX=1, cmd_sent=0, resp_rdy=0, resp=0x00, held while rst=1.
REQ-030 cmd=0x4002, send_cmd pulse -> TX carries frame 0x40 then 0x02 back-to-back; cmd_sent rises 20*BAUD_DIV+2 (+/-1) clocks later.
REQ-031 Model drives byte 0xA5 on RX -> resp_rdy rises about 9.5*BAUD_DIV clocks after start edge, resp=0xA5.
REQ-032 cmd=0x2000 sent, then send_cmd with cmd=0x23FF during high byte -> only 0x20,0x00 transmitted, single cmd_sent rise.
REQ-033 rst asserted mid low byte -> TX high next cycle, cmd_sent stays 0; new cmd=0x6001 afterwards transmits cleanly.
REQ-034 Two successive commands each followed by 0xA5 response -> cmd_sent and resp_rdy each fall at second send_cmd and rise again.
